spi_master: RTL and testbench
=============================

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter RD_WAIT, default 1, meaning turnaround cycles between the last MOSI frame bit and the first MISO sample on read-data frames (range 0..15).
REQ-002 Parameter IDLE_GAP, default 1, meaning minimum cycles SS_n is held high after a transaction before the next one can start (range 1..15).
REQ-003 clk  input  1  single clock; also serves as serial bit clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  transaction request, sampled only when busy=0.
REQ-006 din  input  10  frame: din[9:8] opcode (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data), din[7:0] payload.
REQ-007 busy  output  1  high from accept edge until return to IDLE.
REQ-008 done  output  1  one-cycle pulse at transaction end.
REQ-009 dout  output  8  byte received on MISO during read-data frame.
REQ-010 dout_valid  output  1  one-cycle pulse, coincident with done, only for opcode 11.
REQ-011 SS_n  output  1  slave select, active low, registered.
REQ-012 MOSI  output  1  serial data to slave, registered.
REQ-013 MISO  input  1  serial data from slave.

Function
REQ-014 States SHALL be IDLE, SEL, CMD, SHIFT, WAIT, READ, GAP; edge Tn = n-th rising edge after accept edge T0; "cycle n" = interval following Tn.
REQ-015 IDLE: start=1 at edge T0 -> latch din, SS_n=0, MOSI=0, busy=1, go SEL; start=0 -> stay, SS_n=1.
REQ-016 SEL (cycle 0): SS_n=0, MOSI=0; unconditional -> CMD.
REQ-017 CMD (cycle 1): MOSI=latched din[9] (command bit); -> SHIFT.
REQ-018 SHIFT (cycles 2..11): MOSI=latched din[11-n], MSB first, 10 bits; 4-bit down-counter 9..0 selects bit.
REQ-019 After bit 0: opcode 11 -> WAIT (or READ directly if RD_WAIT=0); other opcodes -> GAP at edge T12.
REQ-020 WAIT (cycles 12..11+RD_WAIT): SS_n=0, MOSI=0.
REQ-021 READ: MISO sampled on edges T(13+RD_WAIT)..T(20+RD_WAIT), bit 7 first, shifted into 8-bit register; MOSI=0.
REQ-022 Entry into GAP: SS_n=1, MOSI=0, done=1 for one cycle; for opcode 11 dout updated with shifted byte and dout_valid=1 same cycle.
REQ-023 Non-read write/addr transaction: done at edge T12; read-data: done at edge T(20+RD_WAIT).
REQ-024 GAP: SS_n=1 for IDLE_GAP cycles, then IDLE with busy=0; start accepted no earlier than first IDLE edge.
REQ-025 start while busy=1 SHALL be ignored, not queued; din changes while busy SHALL not affect the frame in progress.
REQ-026 dout SHALL hold its value until the next read-data completion; not changed by other opcodes.
REQ-027 SS_n SHALL never glitch low outside SEL..READ; MOSI=0 whenever SS_n=1.
REQ-028 Illegal/unreachable state encodings SHALL return to IDLE on next edge with SS_n=1.

Reset
REQ-029 rst=1 at any edge SHALL force state IDLE, SS_n=1, MOSI=0, busy=0, done=0, dout_valid=0, dout=8'h00, counters cleared.
REQ-030 rst mid-transaction SHALL abort immediately: SS_n=1 at that edge, no done or dout_valid pulse, dout unchanged from 0 reset value.
REQ-031 rst has priority over start at the same edge.

Verification
REQ-032 Write-addr: din=10'b00_1010_0101, start at T0 -> MOSI cycles 1..11 = 0,0,0,1,0,1,0,0,1,0,1; SS_n high and done=1 at T12; dout_valid=0.
REQ-033 Read-data, RD_WAIT=1: din=10'b11_0000_0000, slave model drives MISO 8'hC3 MSB first in cycles 13..20 -> done=1, dout_valid=1, dout=8'hC3 at T21.
REQ-034 Back-to-back: start held high continuously, IDLE_GAP=1 -> second SS_n falling edge exactly two cycles after first done; exactly one done per transaction.
REQ-035 start pulses during cycles 3 and 8 of active write -> ignored; single transaction, single done.
REQ-036 rst at T6 of read-data -> SS_n=1, busy=0 at T6; no done/dout_valid; next start yields normal transaction.
REQ-037 End-to-end with slave: wr-addr 8'h10, wr-data 8'h5A, rd-addr 8'h10, rd-data -> dout=8'h5A.

Source files
------------

// File: rtl/spi_master.sv
// SPI master: one 10-bit frame per transaction (command bit + opcode + payload),
// with an optional 8-bit MISO read phase for read-data frames.
module spi_master #(
  parameter int unsigned RD_WAIT  = 1,
  parameter int unsigned IDLE_GAP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] din,
  output logic       busy,
  output logic       done,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEL   = 3'd1,
    CMD   = 3'd2,
    SHIFT = 3'd3,
    WAIT  = 3'd4,
    READ  = 3'd5,
    GAP   = 3'd6
  } state_t;

  localparam logic [3:0] WAIT_LD = (RD_WAIT > 0) ? 4'(RD_WAIT - 1) : 4'd0;
  localparam logic [3:0] GAP_LD  = 4'(IDLE_GAP - 1);

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [9:0] frame, frame_n;
  logic [7:0] rx, rx_n;
  logic [7:0] dout_n;
  logic       done_n, dv_n, mosi_n, ss_n_n, busy_n;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    frame_n = frame;
    rx_n    = rx;
    dout_n  = dout;
    done_n  = 1'b0;
    dv_n    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          frame_n = din;
          state_n = SEL;
        end
      end
      SEL: state_n = CMD;
      CMD: begin
        state_n = SHIFT;
        cnt_n   = 4'd9;
      end
      SHIFT: begin
        if (cnt != 4'd0) begin
          cnt_n = cnt - 4'd1;
        end else if (frame[9:8] == 2'b11) begin
          if (RD_WAIT == 0) begin
            state_n = READ;
            cnt_n   = 4'd7;
          end else begin
            state_n = WAIT;
            cnt_n   = WAIT_LD;
          end
        end else begin
          state_n = GAP;
          cnt_n   = GAP_LD;
          done_n  = 1'b1;
        end
      end
      WAIT: begin
        if (cnt != 4'd0) begin
          cnt_n = cnt - 4'd1;
        end else begin
          state_n = READ;
          cnt_n   = 4'd7;
        end
      end
      READ: begin
        // Last sample lands on the same edge that enters GAP and publishes dout.
        rx_n = {rx[6:0], MISO};
        if (cnt != 4'd0) begin
          cnt_n = cnt - 4'd1;
        end else begin
          state_n = GAP;
          cnt_n   = GAP_LD;
          done_n  = 1'b1;
          dv_n    = 1'b1;
          dout_n  = rx_n;
        end
      end
      GAP: begin
        if (cnt != 4'd0) cnt_n = cnt - 4'd1;
        else             state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    // Pin registers are decoded from the next state so they change on the same edge.
    mosi_n = 1'b0;
    if (state_n == CMD)        mosi_n = frame_n[9];
    else if (state_n == SHIFT) mosi_n = frame_n[cnt_n];
    ss_n_n = !(state_n inside {SEL, CMD, SHIFT, WAIT, READ});
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      frame      <= '0;
      rx         <= '0;
      dout       <= '0;
      done       <= 1'b0;
      dout_valid <= 1'b0;
      MOSI       <= 1'b0;
      SS_n       <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      frame      <= frame_n;
      rx         <= rx_n;
      dout       <= dout_n;
      done       <= done_n;
      dout_valid <= dv_n;
      MOSI       <= mosi_n;
      SS_n       <= ss_n_n;
      busy       <= busy_n;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: a register-file slave on the SPI pins and a
// transaction-level reference model predicting dout, dout_valid and done latency.
module tb_spi_master;

  localparam int RD_WAIT  = 1;
  localparam int IDLE_GAP = 1;

  logic       clk = 1'b0;
  logic       rst, start, MISO;
  logic [9:0] din;
  logic       busy, done, dout_valid, SS_n, MOSI;
  logic [7:0] dout;

  spi_master #(.RD_WAIT(RD_WAIT), .IDLE_GAP(IDLE_GAP)) dut (
    .clk(clk), .rst(rst), .start(start), .din(din), .busy(busy), .done(done),
    .dout(dout), .dout_valid(dout_valid), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] din;
    logic       dv;
    logic [7:0] dout;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0, n_total = 0, n_done = 0, n_issued = 0, mosi_err = 0;
  int   cyc = 0, sel_cyc = 0, last_done_cyc = -1, gap_from = 0;
  bit   gap_chk = 1'b0;

  // reference model state (fed from din at issue time)
  logic [7:0] m_mem [256];
  logic [7:0] m_addr = '0, m_last = '0;
  // slave state (fed from the MOSI pin)
  logic [7:0]  s_mem [256];
  logic [7:0]  s_addr = '0, s_byte = '0;
  logic [10:0] s_bits = '0, s_frame = '0;
  bit          s_rd = 1'b0;
  int          s_cnt = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model(input logic [9:0] d, output exp_t e);
    case (d[9:8])
      2'b00, 2'b10: m_addr = d[7:0];
      2'b01:        m_mem[m_addr] = d[7:0];
      default:      m_last = m_mem[m_addr];
    endcase
    e.din  = d;
    e.dv   = (d[9:8] == 2'b11);
    e.dout = m_last;
    e.lat  = e.dv ? 20 + RD_WAIT : 12;
  endtask

  // Slave: counts cycles from SS_n falling, collects cmd+frame, answers reads.
  always @(negedge clk) begin
    int k, bi;
    if (SS_n !== 1'b0) begin
      s_cnt = 0;
      if (MOSI !== 1'b0) mosi_err++;
      MISO = 1'($urandom);
    end else begin
      k = s_cnt;
      s_cnt++;
      if (k == 0) s_rd = 1'b0;
      if (k >= 1 && k <= 11) s_bits = {s_bits[9:0], MOSI};
      else if (MOSI !== 1'b0) mosi_err++;
      if (k == 11) begin
        s_frame = s_bits;
        case (s_bits[9:8])
          2'b00, 2'b10: s_addr = s_bits[7:0];
          2'b01:        s_mem[s_addr] = s_bits[7:0];
          default: begin
            s_byte = s_mem[s_addr];
            s_rd   = 1'b1;
          end
        endcase
      end
      if (s_rd && k >= 12 + RD_WAIT && k <= 19 + RD_WAIT) begin
        bi   = 7 - (k - 12 - RD_WAIT);
        MISO = s_byte[bi];
      end else begin
        MISO = 1'($urandom);
      end
    end
  end

  // Monitor: pops one expectation per done pulse.
  logic prev_ss = 1'b1;
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst) begin
      prev_ss = 1'b1;
    end else begin
      if (prev_ss && !SS_n) begin
        if (gap_chk && last_done_cyc > gap_from) chk("b2b_gap", cyc - last_done_cyc, 2);
        sel_cyc = cyc;
      end
      prev_ss = SS_n;
      if (done) begin
        n_done++;
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("dout_valid", int'(dout_valid), int'(mon_e.dv));
          chk("dout", int'(dout), int'(mon_e.dout));
          chk("done_latency", cyc - sel_cyc, mon_e.lat);
          chk("mosi_frame", int'(s_frame), int'({mon_e.din[9], mon_e.din}));
          chk("ss_n_at_done", int'(SS_n), 1);
        end
        last_done_cyc = cyc;
      end else if (dout_valid) begin
        chk("stray_dout_valid", 1, 0);
      end
    end
  end

  task automatic wait_idle(input string name);
    int t = 0;
    while (busy !== 1'b0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) chk(name, 1, 0);
  endtask

  // Called at a negedge; returns at the negedge of cycle 0 (or later with spur).
  task automatic issue(input logic [9:0] d, input bit keep, input bit spur);
    exp_t e;
    wait_idle("timeout_idle");
    din   = d;
    start = 1'b1;
    model(d, e);
    sb.push_back(e);
    n_issued++;
    @(negedge clk);
    if (!keep) begin
      start = 1'b0;
      din   = 10'($urandom);
    end
    if (spur) begin
      for (int i = 1; i <= 8; i++) begin
        @(negedge clk);
        start = (i == 3 || i == 8);
        din   = 10'($urandom);
      end
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] op;
    logic [7:0] pl;
    for (int i = 0; i < 256; i++) begin
      m_mem[i] = 8'(i * 7 + 1);
      s_mem[i] = 8'(i * 7 + 1);
    end
    rst = 1'b1; start = 1'b0; din = '0; MISO = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ss_n", int'(SS_n), 1);
    chk("rst_mosi", int'(MOSI), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_dout_valid", int'(dout_valid), 0);
    chk("rst_dout", int'(dout), 0);
    rst = 1'b0;
    @(negedge clk);

    // directed: write-addr pattern, C3 read, end-to-end 5A round trip
    issue(10'b00_1010_0101, 1'b0, 1'b0);
    issue(10'b00_0010_0000, 1'b0, 1'b0);
    issue(10'b01_1100_0011, 1'b0, 1'b0);
    issue(10'b11_0000_0000, 1'b0, 1'b0);
    issue(10'b00_0001_0000, 1'b0, 1'b0);
    issue(10'b01_0101_1010, 1'b0, 1'b0);
    issue(10'b10_0001_0000, 1'b0, 1'b0);
    issue(10'b11_0000_0000, 1'b0, 1'b0);
    // start pulses while busy must be ignored
    issue(10'b01_0011_1100, 1'b0, 1'b1);
    issue(10'b11_0101_0101, 1'b0, 1'b1);

    // back-to-back with start held high
    wait_idle("timeout_b2b");
    gap_from = cyc;
    gap_chk  = 1'b1;
    issue(10'b00_0000_0011, 1'b1, 1'b0);
    issue(10'b01_1110_0111, 1'b1, 1'b0);
    issue(10'b11_0000_0000, 1'b1, 1'b0);
    issue(10'b01_0001_1000, 1'b0, 1'b0);
    @(negedge clk);
    wait_idle("timeout_b2b_end");
    gap_chk = 1'b0;

    // reset during a read-data frame at T6
    din   = 10'b11_0000_0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ss_n", int'(SS_n), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_dout_valid", int'(dout_valid), 0);
    chk("abort_dout", int'(dout), 0);
    chk("abort_mosi", int'(MOSI), 0);
    m_last = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(10'b11_0000_0000, 1'b0, 1'b0);

    // randomized traffic over a small address window so reads hit writes
    repeat (40) begin
      op = 2'($urandom);
      pl = (op == 2'b00 || op == 2'b10) ? 8'($urandom_range(8'h40, 8'h47)) : 8'($urandom);
      issue({op, pl}, 1'b0, ($urandom % 4) == 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    wait_idle("timeout_final");
    repeat (30) @(negedge clk);
    chk("done_count", n_done, n_issued);
    chk("mosi_while_idle_or_gap", mosi_err, 0);
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
